// File: rtl/servant_uart_rx.sv
// rtl/servant_uart_rx.sv - Wishbone-slave 8N1 UART receiver with receive FIFO and sticky error flags.
// Optional even-parity bit support is enabled by defining SERVANT_UART_RX_PARITY_EN.
module servant_uart_rx #(
  parameter int CLKS_PER_BIT = 278,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  input  logic        i_rx,
  output logic        o_irq
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERVANT_UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rxs_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            push, ferr_set, sample;
  logic            ack_q, ferr_q, ovr_q, perr;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            empty, full, pop, push_ok, ovr_set, clr;

  assign sample = (timer_q == '0);

`ifdef SERVANT_UART_RX_PARITY_EN
  logic perr_set, perr_q;
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = sample ? timer_q : timer_q - TW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
    perr_set  = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (!rxs_q) begin
        timer_d = HALF_LOAD;
        state_d = S_START;
      end
      S_START: if (sample) begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          timer_d   = FULL_LOAD;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: if (sample) begin
        shift_d   = {rxs_q, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        timer_d   = FULL_LOAD;
        if (bit_idx_q == 3'd7) begin
`ifdef SERVANT_UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef SERVANT_UART_RX_PARITY_EN
      S_PARITY: if (sample) begin
        perr_set = ^{shift_q, rxs_q};
        timer_d  = FULL_LOAD;
        state_d  = S_STOP;
      end
`endif
      S_STOP: if (sample) begin
        if (rxs_q) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          ferr_set = 1'b1;
          state_d  = S_BREAK;
        end
      end
      S_BREAK: if (rxs_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus side effects (pop, flag clear) are taken in the ack cycle so they match the returned data.
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = ack_q & ~i_wb_we & ~i_wb_adr & ~empty;
  assign clr     = ack_q & i_wb_we & i_wb_adr;
  assign push_ok = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    o_wb_rdt = '0;
    if (ack_q) begin
      if (i_wb_adr)
        o_wb_rdt = {16'h0, 8'(count_q), 3'b0, perr, ovr_q, ferr_q, full, ~empty};
      else if (!empty)
        o_wb_rdt = {24'h0, mem_q[rd_ptr_q]};
    end
  end

  assign o_wb_ack = ack_q;
  assign o_irq    = ~empty;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ack_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      rx_meta_q <= i_rx;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ack_q     <= i_wb_cyc & ~ack_q;
      ferr_q    <= ferr_set | (ferr_q & ~(clr & i_wb_dat[2]));
      ovr_q     <= ovr_set | (ovr_q & ~(clr & i_wb_dat[3]));
      count_q   <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

`ifdef SERVANT_UART_RX_PARITY_EN
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) perr_q <= 1'b0;
    else           perr_q <= perr_set | (perr_q & ~(clr & i_wb_dat[4]));
  end
  logic unused_dat;
  assign unused_dat = ^{i_wb_dat[31:5], i_wb_dat[1:0]};
`else
  logic unused_dat;
  assign unused_dat = ^{i_wb_dat[31:4], i_wb_dat[1:0]};
`endif

  always_ff @(posedge wb_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

endmodule

// File: tb/tb_servant_uart_rx.sv
// tb/tb_servant_uart_rx.sv - Directed and randomized bench for servant_uart_rx against a queue-based model.
module tb_servant_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int LAT_MAX = 4 + CPB / 2 + 9 * CPB;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        i_wb_adr = 1'b0;
  logic [31:0] i_wb_dat = '0;
  logic        i_wb_we = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic        i_rx = 1'b1;
  logic        o_irq;

  servant_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat),
    .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
    .i_rx(i_rx), .o_irq(o_irq)
  );

  always #5 wb_clk = ~wb_clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  bit m_ferr = 0, m_ovr = 0, m_perr = 0;
  int cyc_cnt, irq_lat;
  logic [31:0] r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int n = exp_q.size();
    return {16'h0, 8'(n), 3'b0, m_perr, m_ovr, m_ferr, n == DEPTH, n != 0};
  endfunction

  task automatic drive(input logic lvl, input int n);
    i_rx = lvl;
    repeat (n) begin
      @(posedge wb_clk); #1;
      cyc_cnt++;
      if (o_irq && irq_lat < 0) irq_lat = cyc_cnt;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_low_bits, input bit par);
    cyc_cnt = 0;
    irq_lat = -1;
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
`ifdef SERVANT_UART_RX_PARITY_EN
    drive(par, CPB);
    if (par != ^b) m_perr = 1;
`else
    if (par) cyc_cnt = cyc_cnt;
`endif
    if (stop_low_bits == 0) begin
      drive(1'b1, CPB);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else m_ovr = 1;
    end else begin
      drive(1'b0, stop_low_bits * CPB);
      m_ferr = 1;
      drive(1'b1, CPB);
    end
  endtask

  task automatic wb_access(input logic adr, input logic we, input logic [31:0] dat, output logic [31:0] rdt);
    bit got = 0;
    i_wb_adr = adr; i_wb_we = we; i_wb_dat = dat; i_wb_cyc = 1'b1;
    rdt = 32'hDEAD_BEEF;
    for (int k = 0; k < 4 && !got; k++) begin
      @(posedge wb_clk); #1;
      if (o_wb_ack) begin rdt = o_wb_rdt; got = 1; end
    end
    chk("ack_seen", 32'(got), 32'd1);
    @(posedge wb_clk); #1;
    chk("ack_pulse", 32'(o_wb_ack), 32'd0);
    i_wb_cyc = 1'b0; i_wb_we = 1'b0; i_wb_dat = '0;
  endtask

  task automatic read_status(input string tag);
    logic [31:0] rd;
    logic [31:0] e = exp_status();
    wb_access(1'b1, 1'b0, 32'h0, rd);
    chk(tag, rd, e);
  endtask

  task automatic read_data(input string tag);
    logic [31:0] rd;
    logic [31:0] e = 32'h0;
    if (exp_q.size() != 0) e = {24'h0, exp_q.pop_front()};
    wb_access(1'b0, 1'b0, 32'h0, rd);
    chk(tag, rd, e);
  endtask

  task automatic write_status(input logic [31:0] v);
    logic [31:0] rd;
    wb_access(1'b1, 1'b1, v, rd);
    if (v[2]) m_ferr = 0;
    if (v[3]) m_ovr = 0;
    if (v[4]) m_perr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge wb_clk);
    #1;
    chk("rst_ack", 32'(o_wb_ack), 32'd0);
    chk("rst_rdt", o_wb_rdt, 32'h0);
    chk("rst_irq", 32'(o_irq), 32'd0);
    wb_rst_n = 1'b1;
    drive(1'b1, 4);

    send_byte(8'h55, 0, 1'b0);
    chk("latency", 32'(irq_lat > 0 && irq_lat <= LAT_MAX), 32'd1);
    chk("status_one_const", exp_status(), 32'h0000_0101);
    read_status("status_one");
    read_data("data_55");
    read_status("status_empty");

    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h3C, 0, 1'b0);
    send_byte(8'hFF, 0, 1'b1);
    send_byte(8'h00, 0, 1'b0);
    read_status("status_full");
    send_byte(8'($urandom), 0, 1'b0);
    read_status("status_ovr");
    wb_access(1'b0, 1'b1, 32'h0000_00AB, r);
    read_status("status_after_data_write");
    for (int i = 0; i < DEPTH; i++) read_data("data_in_order");
    read_data("data_empty");
    write_status(32'h8);
    read_status("status_ovr_cleared");

    send_byte(8'($urandom), 3, 1'b0);
    chk("no_false_start", 32'(o_irq), 32'd0);
    read_status("status_ferr");
    send_byte(8'h12, 0, 1'b0);
    read_data("data_12");
    write_status(32'h4);
    read_status("status_ferr_cleared");

    drive(1'b0, CPB / 4);
    drive(1'b1, 2 * CPB);
    chk("glitch_irq", 32'(o_irq), 32'd0);
    read_status("status_glitch");

    send_byte(8'($urandom), 0, 1'b0);
    chk("pre_reset_irq", 32'(o_irq), 32'd1);
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(1'(8'h77 >> i), CPB);
    wb_rst_n = 1'b0;
    #1;
    chk("mid_reset_irq", 32'(o_irq), 32'd0);
    chk("mid_reset_ack", 32'(o_wb_ack), 32'd0);
    exp_q.delete();
    m_ferr = 0; m_ovr = 0; m_perr = 0;
    i_rx = 1'b1;
    repeat (2) @(posedge wb_clk);
    #1;
    wb_rst_n = 1'b1;
    drive(1'b1, 2 * CPB);
    read_status("status_after_reset");
    read_data("data_after_reset");

`ifdef SERVANT_UART_RX_PARITY_EN
    send_byte(8'h03, 0, 1'b1);
    read_status("status_perr");
    read_data("data_03_bad_par");
    send_byte(8'h03, 0, 1'b0);
    read_status("status_perr_kept");
    read_data("data_03_good_par");
    write_status(32'h10);
    read_status("status_perr_cleared");
`endif

    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++)
        send_byte(8'($urandom), ($urandom_range(0, 5) == 0) ? 2 : 0, 1'($urandom));
      read_status("rand_status");
      for (int k = 0; k <= n; k++) read_data("rand_data");
      write_status(32'h1C);
      read_status("rand_status_cleared");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
